// File: rtl/instr_loader.sv
// instr_loader: boot-time loader that packs a big-endian byte stream into 32-bit words
// and writes them to instruction memory from word address 0, holding the core meanwhile.
module instr_loader #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              aborted
);
    typedef enum logic [1:0] {IDLE, RECV, WRITE, FIN} state_t;
    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, waddr_q, waddr_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              abrt_q, abrt_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            wdata_q <= '0;
            abrt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            abrt_q  <= abrt_d;
        end
    end
    // The write-side address/data live in their own registers so they hold between writes.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        idx_d   = idx_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        abrt_d  = abrt_q;
        case (state_q)
            IDLE: if (start) begin
                len_d   = load_len > MAX_LEN ? MAX_LEN : load_len;
                cnt_d   = '0;
                addr_d  = '0;
                idx_d   = '0;
                abrt_d  = 1'b0;
                state_d = load_len == '0 ? FIN : RECV;
            end
            RECV: if (abort) begin
                abrt_d  = 1'b1;
                state_d = FIN;
            end else if (byte_valid) begin
                word_d = {word_q[15:0], byte_data};
                idx_d  = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    wdata_d = {word_q, byte_data};
                    waddr_d = addr_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                cnt_d   = cnt_q + 1'b1;
                addr_d  = addr_q + 1'b1;
                abrt_d  = abort;
                state_d = (abort || cnt_d == len_q) ? FIN : RECV;
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    assign byte_ready = state_q == RECV && !abort;
    assign mem_we     = state_q == WRITE;
    assign mem_addr   = waddr_q;
    assign mem_wdata  = wdata_q;
    assign busy       = state_q != IDLE;
    assign cpu_hold   = busy;
    assign done       = state_q == FIN && !abrt_q;
    assign aborted    = state_q == FIN && abrt_q;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized loads against a word-list reference model; a monitor
// pops expected writes and completion pulses from scoreboard queues.
module tb_instr_loader;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, byte_valid = 1'b0;
    logic [8:0]  load_len = '0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, cpu_hold, busy, done, aborted;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    always #5 clk = ~clk;
    instr_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .load_len(load_len), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .aborted(aborted)
    );
    typedef struct {int addr; logic [31:0] data; int gap;} wr_t;
    typedef struct {logic [1:0] kind; int rsel;} end_t;
    wr_t  exp_wr[$];
    end_t exp_end[$];
    wr_t  w;
    end_t e;
    int   n_chk = 0, n_pass = 0, cyc = 0, last_we = -100, start_cyc = -100;
    logic prev_fin = 1'b0;
    logic [7:0] b [0:1027];
    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    endtask
    // Monitor: everything the DUT presents is compared against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (start && !busy) start_cyc = cyc;
            chk("hold_eq_busy", cpu_hold, busy);
            if (abort) chk("ready_during_abort", byte_ready, 0);
            if (prev_fin) chk("hold_after_end", cpu_hold, 0);
            if (mem_we) begin
                if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    w = exp_wr.pop_front();
                    chk("write_addr", mem_addr, w.addr);
                    chk("write_data", mem_wdata, w.data);
                    if (w.gap > 0) chk("write_gap", cyc - last_we, w.gap);
                end
                last_we = cyc;
            end
            if (done || aborted) begin
                if (exp_end.size() == 0) chk("unexpected_end", {done, aborted}, 0);
                else begin
                    e = exp_end.pop_front();
                    chk("end_kind", {done, aborted}, e.kind);
                    if (e.rsel == 0) chk("done_after_write", cyc - last_we, 1);
                    if (e.rsel == 1) chk("done_after_start", cyc - start_cyc, 1);
                end
            end
            prev_fin = done || aborted;
        end
    end
    task automatic fill_rand();
        for (int i = 0; i < 1028; i++) b[i] = 8'($urandom);
    endtask
    task automatic set_in(int n, int nb, int mode, int ak, bit tog);
        byte_valid = n < nb && (mode == 0 || (mode == 1 && tog) || (mode == 2 && $urandom_range(1) == 1));
        byte_data  = b[n];
        abort      = ak >= 0 && n == ak;
    endtask
    // One load: len words requested, mode 0 held / 1 toggled / 2 random valid,
    // ak = abort after that many accepted bytes, rk = async reset after that many.
    task automatic run_load(int len, int mode, int ak, int rk);
        int words = len > 256 ? 256 : len;
        int nb = 4 * words;
        int nwr = ak >= 0 ? ak / 4 : (rk >= 0 ? rk / 4 : words);
        int n = 0, cycles = 0;
        bit hs, bz = 1'b1, tog = 1'b1;
        for (int i = 0; i < nwr; i++) begin
            wr_t x;
            x.addr = i;
            x.data = {b[4*i], b[4*i+1], b[4*i+2], b[4*i+3]};
            x.gap  = (mode == 0 && i > 0) ? 5 : 0;
            exp_wr.push_back(x);
        end
        if (rk < 0) begin
            end_t y;
            y.kind = ak >= 0 ? 2'b01 : 2'b10;
            y.rsel = ak >= 0 ? 2 : (words == 0 ? 1 : 0);
            exp_end.push_back(y);
        end
        @(posedge clk); #1;
        start = 1'b1; load_len = 9'(len);
        @(posedge clk); #1;
        start = 1'b0;
        set_in(n, nb, mode, ak, tog);
        do begin
            @(negedge clk);
            hs = byte_valid && byte_ready;
            bz = busy;
            @(posedge clk); #1;
            if (hs) n++;
            cycles++;
            if (rk >= 0 && n == rk) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_ctrl", {byte_ready, mem_we, cpu_hold, busy, done, aborted}, 0);
                chk("rst_addr", mem_addr, 0);
                chk("rst_wdata", mem_wdata, 0);
                byte_valid = 1'b0;
                repeat (2) @(posedge clk);
                #3 rst_n = 1'b1;
                repeat (3) @(negedge clk);
                chk("idle_after_reset", busy, 0);
                break;
            end
            tog = !tog;
            start = cycles == 3 && ak < 0 && words > 0;
            load_len = 9'($urandom_range(0, 300));
            set_in(n, nb, mode, ak, tog);
        end while (bz && cycles < 20000);
        start = 1'b0; byte_valid = 1'b0; abort = 1'b0;
        if (cycles >= 20000) chk("load_timeout", cycles, 0);
        chk("accepted_bytes", n, ak >= 0 ? ak : (rk >= 0 ? rk : nb));
    endtask
    initial begin
        int len, ak;
        #12;
        chk("reset_ctrl", {byte_ready, mem_we, cpu_hold, busy, done, aborted}, 0);
        chk("reset_addr", mem_addr, 0);
        chk("reset_wdata", mem_wdata, 0);
        @(posedge clk); #3 rst_n = 1'b1;
        {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]} = 64'h00000013_DEADBEEF;
        run_load(2, 0, -1, -1);
        {b[0], b[1], b[2], b[3]} = 32'h12345678;
        run_load(1, 1, -1, -1);
        for (int i = 0; i < 1028; i++) b[i] = 8'(i);
        run_load(300, 0, -1, -1);
        fill_rand();
        run_load(3, 0, 6, -1);
        fill_rand();
        run_load(2, 2, -1, -1);
        run_load(0, 0, -1, -1);
        repeat (14) begin
            fill_rand();
            len = $urandom_range(0, 12);
            ak = (len > 0 && $urandom_range(2) == 0) ? $urandom_range(0, 4 * len - 1) : -1;
            run_load(len, $urandom_range(0, 2), ak, -1);
        end
        fill_rand();
        b[0] = 8'hA5;
        run_load(4, 0, -1, 6);
        fill_rand();
        run_load(2, 1, -1, -1);
        repeat (3) @(negedge clk);
        chk("writes_outstanding", exp_wr.size(), 0);
        chk("ends_outstanding", exp_end.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
